spike_rate_encoder: RTL

- Producer side of the network's `sample`/`sample_ready` input handshake.
- Accepts one frame of N_INPUTS pixel intensities and converts each pixel into a deterministic rate-coded spike train using a per-channel phase accumulator.
- Supplies one `in_spikes` vector per `sample` request, for exactly N_CYCLES requests per frame. It then signals frame completion and accepts the next frame.

---
 rtl/spiker_enc_pkg.sv | 17 +
 rtl/spike_accum_channel.sv | 50 +++++
 rtl/spike_rate_encoder.sv | 109 ++++++++++
 3 files changed

// File: rtl/spiker_enc_pkg.sv
// ============================================================================
// Module  : spiker_enc_pkg
// Purpose : Shared state encoding for the spike rate encoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spiker_enc_pkg;

  typedef enum logic [0:0] {
    ENC_IDLE = 1'b0,
    ENC_RUN  = 1'b1
  } enc_state_t;

endpackage : spiker_enc_pkg

`default_nettype wire

// File: rtl/spike_accum_channel.sv
// ============================================================================
// Module  : spike_accum_channel
// Purpose : One pixel phase accumulator; the accumulator carry-out is the spike.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_accum_channel #(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic [PIX_W-1:0] pix_in,
  output logic             spike
);

  logic [PIX_W-1:0] r_pix;
  logic [PIX_W-1:0] r_acc;
  logic             r_spike;
  logic [PIX_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_pix};

  // Load is step 1 from a zero accumulator, so it can never carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix   <= '0;
      r_acc   <= '0;
      r_spike <= 1'b0;
    end else if (load) begin
      r_pix   <= pix_in;
      r_acc   <= pix_in;
      r_spike <= 1'b0;
    end else if (clear) begin
      r_acc   <= '0;
      r_spike <= 1'b0;
    end else if (step) begin
      r_acc   <= w_sum[PIX_W-1:0];
      r_spike <= w_sum[PIX_W];
    end
  end

  assign spike = r_spike;

endmodule : spike_accum_channel

`default_nettype wire

// File: rtl/spike_rate_encoder.sv
// ============================================================================
// Module  : spike_rate_encoder
// Purpose : Converts a pixel frame into N_CYCLES rate-coded spike vectors
//           delivered over the sample/sample_ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_rate_encoder
  import spiker_enc_pkg::*;
#(
  parameter int N_INPUTS = 8,
  parameter int PIX_W    = 8,
  parameter int N_CYCLES = 10,
  parameter int CNT_W    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_valid,
  output logic                      frame_ready,
  input  logic [N_INPUTS*PIX_W-1:0] frame_data,
  input  logic                      sample,
  output logic                      sample_ready,
  output logic [N_INPUTS-1:0]       in_spikes,
  output logic                      frame_done,
  output logic                      underrun
);

  localparam int             FRAME_W = N_INPUTS * PIX_W;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_CYCLES);

  enc_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_frame_done;
  logic             r_underrun;

  logic w_load;
  logic w_consume;
  logic w_last;
  logic w_step;
  logic w_clear;

  assign frame_ready  = (r_state == ENC_IDLE);
  assign sample_ready = (r_state == ENC_RUN);

  assign w_load    = frame_valid && (r_state == ENC_IDLE);
  assign w_consume = sample && (r_state == ENC_RUN);
  assign w_last    = (r_count == C_LAST);
  assign w_step    = w_consume && !w_last;
  assign w_clear   = w_consume && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ENC_IDLE;
      r_count      <= '0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      // A sample arriving on a load edge is still an underrun.
      r_underrun   <= sample && (r_state != ENC_RUN);
      case (r_state)
        ENC_IDLE: begin
          if (w_load) begin
            r_count <= CNT_W'(1);
            r_state <= ENC_RUN;
          end
        end
        ENC_RUN: begin
          if (w_clear) begin
            r_count      <= '0;
            r_frame_done <= 1'b1;
            r_state      <= ENC_IDLE;
          end else if (w_step) begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: r_state <= ENC_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_chan
      spike_accum_channel #(
        .PIX_W (PIX_W)
      ) u_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_load),
        .step   (w_step),
        .clear  (w_clear),
        .pix_in (frame_data[gi*PIX_W +: PIX_W]),
        .spike  (in_spikes[gi])
      );
    end : g_chan
  endgenerate

  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

  // Keeps the frame-width helper tied to the port width it describes.
  if (FRAME_W != $bits(frame_data)) begin : g_width_guard
    $error("frame_data width mismatch");
  end : g_width_guard

endmodule : spike_rate_encoder

`default_nettype wire
